// File: rtl/pyrxlnctrl_pack_pkg.sv
// Shared types and constants for the rx payload packer.
package pyrx_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 10;
    localparam int CNT_W  = 13;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH,
        DONE
    } state_e;

    // Round a bit count up to whole bytes.
    function automatic logic [LEN_W-1:0] bytes_from_bits(
        input logic [CNT_W-1:0] b
    );
        return b[12:3] + {{(LEN_W-1){1'b0}}, |b[2:0]};
    endfunction

endpackage

// File: rtl/pyrxlnctrl_pack_if.sv
// Word-write bus into the rx ACL/SCO payload buffers.
interface pyrxlnctrl_pack_if
    import pyrx_pkg::*;
();

    logic [ADDR_W-1:0] rxlnctrl_addr;
    logic [WORD_W-1:0] rxlnctrl_din;
    logic              rxlnctrl_we;

    modport master (
        output rxlnctrl_addr,
        output rxlnctrl_din,
        output rxlnctrl_we
    );

    modport slave (
        input rxlnctrl_addr,
        input rxlnctrl_din,
        input rxlnctrl_we
    );

endinterface

// File: rtl/pyrxlnctrl_pack.sv
// Serial-to-parallel packer: LSB-first payload bits into 32-bit buffer words,
// with a flush of the partial tail word and a per-packet status report.
module pyrxlnctrl_pack
    import pyrx_pkg::*;
(
    input  logic                clk_6M,
    input  logic                rst,
    input  logic                dec_py_period,
    input  logic                dec_pybit,
    input  logic                dec_pybit_valid,
    input  logic [LEN_W-1:0]    dec_pylenByte,
    input  logic                py_endp,
    pyrxlnctrl_pack_if.master   buf_wr,
    output logic [LEN_W-1:0]    rxpy_bytecnt,
    output logic                rxpy_done_p,
    output logic                rxpy_trunc,
    output logic                rxpy_overrun
);

    state_e              state_q;
    logic [CNT_W-1:0]    bitcnt_q;
    logic [CNT_W-1:0]    len_bits_q;
    logic [WORD_W-1:0]   shadow_q;
    logic                prev_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   din_q;
    logic [LEN_W-1:0]    bytecnt_q;
    logic                done_q;
    logic                trunc_q;
    logic                overrun_q;

    logic                rise;
    logic                fall;
    logic                accept;
    logic                full;
    logic [CNT_W-1:0]    bitcnt_d;
    logic [WORD_W-1:0]   word_d;

    always_comb begin
        rise     = dec_py_period & ~prev_q;
        fall     = ~dec_py_period & prev_q;
        accept   = dec_pybit_valid & (bitcnt_q < len_bits_q);
        full     = accept & (bitcnt_q[4:0] == 5'd31);
        bitcnt_d = bitcnt_q + {{(CNT_W-1){1'b0}}, accept};
        word_d   = shadow_q;
        if (accept) begin
            word_d[bitcnt_q[4:0]] = dec_pybit;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            len_bits_q <= '0;
            shadow_q   <= '0;
            prev_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            bytecnt_q  <= '0;
            done_q     <= 1'b0;
            trunc_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            prev_q <= dec_py_period;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q    <= COLLECT;
                        len_bits_q <= {dec_pylenByte, 3'b000};
                        bitcnt_q   <= '0;
                        shadow_q   <= '0;
                        trunc_q    <= 1'b0;
                        overrun_q  <= 1'b0;
                        bytecnt_q  <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        bitcnt_q <= bitcnt_d;
                        shadow_q <= full ? '0 : word_d;
                    end
                    if (full) begin
                        we_q   <= 1'b1;
                        addr_q <= bitcnt_q[12:5];
                        din_q  <= word_d;
                    end
                    // Length reached takes priority: no truncation possible.
                    if (bitcnt_q == len_bits_q) begin
                        state_q <= FLUSH;
                        if (dec_pybit_valid) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (py_endp | fall) begin
                        state_q <= FLUSH;
                        trunc_q <= bitcnt_d < len_bits_q;
                    end
                end
                FLUSH: begin
                    if (bitcnt_q[4:0] != 5'd0) begin
                        we_q   <= 1'b1;
                        addr_q <= bitcnt_q[12:5];
                        din_q  <= shadow_q;
                    end
                    done_q    <= 1'b1;
                    bytecnt_q <= bytes_from_bits(bitcnt_q);
                    state_q   <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign buf_wr.rxlnctrl_we   = we_q;
    assign buf_wr.rxlnctrl_addr = addr_q;
    assign buf_wr.rxlnctrl_din  = din_q;
    assign rxpy_bytecnt         = bytecnt_q;
    assign rxpy_done_p          = done_q;
    assign rxpy_trunc           = trunc_q;
    assign rxpy_overrun         = overrun_q;

endmodule

// File: tb/tb_pyrxlnctrl_pack.sv
// Directed bench for the rx payload packer.
module tb_pyrxlnctrl_pack;
    import pyrx_pkg::*;

    logic        clk_6M = 1'b0;
    logic        rst;
    logic        period;
    logic        pybit;
    logic        valid;
    logic        endp;
    logic [9:0]  len;
    logic [9:0]  bytecnt;
    logic        done_p;
    logic        trunc;
    logic        overrun;

    pyrxlnctrl_pack_if bus ();

    pyrxlnctrl_pack dut (
        .clk_6M          (clk_6M),
        .rst             (rst),
        .dec_py_period   (period),
        .dec_pybit       (pybit),
        .dec_pybit_valid (valid),
        .dec_pylenByte   (len),
        .py_endp         (endp),
        .buf_wr          (bus),
        .rxpy_bytecnt    (bytecnt),
        .rxpy_done_p     (done_p),
        .rxpy_trunc      (trunc),
        .rxpy_overrun    (overrun)
    );

    always #5 clk_6M = ~clk_6M;

    int cyc = 0;
    always @(posedge clk_6M) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic        done_seen;
    logic [9:0]  d_bc;
    logic        d_tr;
    logic        d_ov;
    int          last_cyc;

    always @(negedge clk_6M) begin
        if (bus.rxlnctrl_we === 1'b1) begin
            wa.push_back(bus.rxlnctrl_addr);
            wd.push_back(bus.rxlnctrl_din);
            wc.push_back(cyc);
        end
        if (done_p === 1'b1) begin
            done_seen = 1'b1;
            d_bc = bytecnt;
            d_tr = trunc;
            d_ov = overrun;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wc.delete();
        done_seen = 1'b0;
    endtask

    task automatic start_pkt(input logic [9:0] l);
        clear_mon();
        tick();
        len    = l;
        period = 1'b1;
    endtask

    task automatic send_bits(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            valid    = 1'b1;
            pybit    = d[i];
            last_cyc = cyc;
        end
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && !done_seen; i++) @(posedge clk_6M);
        check("done_seen", {31'd0, done_seen}, 32'd1);
        period = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1; period = 1'b0; pybit = 1'b0;
        valid = 1'b0; endp = 1'b0; len = '0;
        done_seen = 1'b0; d_bc = '0; d_tr = 1'b0; d_ov = 1'b0;
        last_cyc = 0;
        repeat (3) tick();
        check("rst_we", {31'd0, bus.rxlnctrl_we}, 32'd0);
        check("rst_addr", {24'd0, bus.rxlnctrl_addr}, 32'd0);
        check("rst_din", bus.rxlnctrl_din, 32'd0);
        check("rst_bc", {22'd0, bytecnt}, 32'd0);
        check("rst_done", {31'd0, done_p}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: exactly one full word
        start_pkt(10'd4);
        send_bits(64'hA5A50F0F, 32);
        wait_done();
        check("t1_nwr", wa.size(), 32'd1);
        if (wa.size() >= 1) begin
            check("t1_addr", {24'd0, wa[0]}, 32'd0);
            check("t1_din", wd[0], 32'hA5A50F0F);
            check("t1_lat", wc[0], last_cyc + 1);
        end
        check("t1_bc", {22'd0, d_bc}, 32'd4);
        check("t1_trunc", {31'd0, d_tr}, 32'd0);
        check("t1_ovr", {31'd0, d_ov}, 32'd0);

        // 2: full word plus one-byte tail
        start_pkt(10'd5);
        send_bits(64'h9C_12345678, 40);
        wait_done();
        check("t2_nwr", wa.size(), 32'd2);
        if (wa.size() >= 2) begin
            check("t2_a0", {24'd0, wa[0]}, 32'd0);
            check("t2_d0", wd[0], 32'h12345678);
            check("t2_a1", {24'd0, wa[1]}, 32'd1);
            check("t2_d1", wd[1], 32'h0000009C);
        end
        check("t2_bc", {22'd0, d_bc}, 32'd5);

        // 3: window closes early
        start_pkt(10'd2);
        send_bits(64'h2AB, 10);
        period = 1'b0;
        wait_done();
        check("t3_nwr", wa.size(), 32'd1);
        if (wa.size() >= 1) begin
            check("t3_addr", {24'd0, wa[0]}, 32'd0);
            check("t3_din", wd[0], 32'h000002AB);
        end
        check("t3_trunc", {31'd0, d_tr}, 32'd1);
        check("t3_bc", {22'd0, d_bc}, 32'd2);

        // 4: more bits than the length
        start_pkt(10'd1);
        send_bits(64'hFA5, 12);
        wait_done();
        check("t4_nwr", wa.size(), 32'd1);
        if (wa.size() >= 1) begin
            check("t4_addr", {24'd0, wa[0]}, 32'd0);
            check("t4_din", wd[0], 32'h000000A5);
        end
        check("t4_ovr", {31'd0, d_ov}, 32'd1);
        check("t4_trunc", {31'd0, d_tr}, 32'd0);
        check("t4_bc", {22'd0, d_bc}, 32'd1);

        // 5: reset mid-packet, then a clean packet
        start_pkt(10'd4);
        send_bits(64'hFFFFF, 20);
        rst    = 1'b1;
        period = 1'b0;
        tick();
        check("t5_we", {31'd0, bus.rxlnctrl_we}, 32'd0);
        check("t5_din", bus.rxlnctrl_din, 32'd0);
        check("t5_bc", {22'd0, bytecnt}, 32'd0);
        check("t5_ovr", {31'd0, overrun}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("t5_nwr", wa.size(), 32'd0);
        check("t5_nodone", {31'd0, done_seen}, 32'd0);
        start_pkt(10'd4);
        send_bits(64'hDEADBEEF, 32);
        wait_done();
        check("t5b_nwr", wa.size(), 32'd1);
        if (wa.size() >= 1) begin
            check("t5b_addr", {24'd0, wa[0]}, 32'd0);
            check("t5b_din", wd[0], 32'hDEADBEEF);
        end
        check("t5b_bc", {22'd0, d_bc}, 32'd4);

        // 6: max length, end pulse on the last bit
        start_pkt(10'd1023);
        for (int i = 0; i < 8184; i++) begin
            tick();
            valid = 1'b1;
            pybit = 1'b1;
            endp  = (i == 8183);
        end
        tick();
        valid = 1'b0;
        endp  = 1'b0;
        wait_done();
        check("t6_nwr", wa.size(), 32'd256);
        for (int i = 0; i < wa.size() && i < 256; i++) begin
            check("t6_addr", {24'd0, wa[i]}, 32'(i));
            check("t6_din", wd[i], (i == 255) ? 32'h00FFFFFF : 32'hFFFFFFFF);
        end
        check("t6_bc", {22'd0, d_bc}, 32'd1023);
        check("t6_trunc", {31'd0, d_tr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
